// File: rtl/freq_gen_block.sv
// rtl/freq_gen_block.sv - programmable square-wave generator (phase-accumulator NCO)
//
// Software requests an output frequency in kHz. A restoring divider computes
// inc = floor(freq_khz * 2^C_ACC_W / REF_KHZ). The phase accumulator advances by inc
// every clock, and its registered MSB drives o_gen_clk.
//
// Optional feature macro: FREQ_GEN_SYNC_APPLY_EN. When it is defined, a new increment
// takes effect only on an accumulator wrap, so period changes are glitch-free.
//
// Ports:
//   i_ref_clk      in   1   reference clock (sole clock)
//   i_rst_n        in   1   asynchronous active-low reset
//   i_freq_khz     in   20  requested output frequency, kHz
//   i_freq_load    in   1   single-cycle request strobe
//   o_busy         out  1   increment computation in progress
//   o_err          out  1   single-cycle pulse: request rejected
//   o_freq_active  out  20  frequency (kHz) currently generated
//   o_gen_clk      out  1   generated square wave
module freq_gen_block #(
  parameter int C_REF_FREQ = 100000000,
  parameter int C_ACC_W    = 32
) (
  input  logic        i_ref_clk,
  input  logic        i_rst_n,
  input  logic [19:0] i_freq_khz,
  input  logic        i_freq_load,
  output logic        o_busy,
  output logic        o_err,
  output logic [19:0] o_freq_active,
  output logic        o_gen_clk
);

  localparam int REF_KHZ = C_REF_FREQ / 1000;
  localparam int DW      = 20 + C_ACC_W;        // dividend / quotient width
  localparam int RW      = 33;                  // shifted remainder width (< 2*divisor)
  localparam int CW      = $clog2(DW + 1);

  localparam logic [RW-1:0] DIVISOR  = RW'(REF_KHZ);
  localparam logic [31:0]   HALF_REF = 32'(REF_KHZ / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dvd_q, dvd_d;      // dividend shifts out the top, quotient shifts in the bottom
  logic [RW-2:0]      rem_q, rem_d;
  logic [19:0]        req_q, req_d;
  logic [C_ACC_W-1:0] inc_q, inc_d;
  logic [C_ACC_W-1:0] acc_q, acc_d;
  logic [19:0]        freq_q, freq_d;
  logic               gen_q, gen_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [RW-1:0]      rem_sh;
  logic               rem_ge;
  logic               apply_ok;
`ifdef FREQ_GEN_SYNC_APPLY_EN
  logic [C_ACC_W:0]   acc_sum;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    req_d   = req_q;
    inc_d   = inc_q;
    freq_d  = freq_q;
    busy_d  = busy_q;
    err_d   = 1'b0;

    rem_sh  = {rem_q, dvd_q[DW-1]};
    rem_ge  = (rem_sh >= DIVISOR);

`ifdef FREQ_GEN_SYNC_APPLY_EN
    acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};
    // Switch on the carry out of the add, or at once when the output is idle.
    apply_ok = acc_sum[C_ACC_W] || (inc_q == '0);
`else
    apply_ok = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_freq_load) begin
          if ({12'b0, i_freq_khz} >= HALF_REF) begin
            err_d = 1'b1;
          end else begin
            req_d   = i_freq_khz;
            dvd_d   = {i_freq_khz, {C_ACC_W{1'b0}}};
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        err_d = i_freq_load;
        rem_d = rem_ge ? (RW-1)'(rem_sh - DIVISOR) : (RW-1)'(rem_sh);
        dvd_d = {dvd_q[DW-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) state_d = S_APPLY;
      end
      S_APPLY: begin
        err_d = i_freq_load;
        if (apply_ok) begin
          inc_d   = dvd_q[C_ACC_W-1:0];
          freq_d  = req_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A zero increment parks the accumulator at 0 so that the output stays low.
    if (inc_q == '0) begin
      acc_d = '0;
      gen_d = 1'b0;
    end else begin
`ifdef FREQ_GEN_SYNC_APPLY_EN
      acc_d = acc_sum[C_ACC_W-1:0];
`else
      acc_d = acc_q + inc_q;
`endif
      gen_d = acc_q[C_ACC_W-1];
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      req_q   <= '0;
      inc_q   <= '0;
      acc_q   <= '0;
      freq_q  <= '0;
      gen_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      inc_q   <= inc_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_err         = err_q;
  assign o_freq_active = freq_q;
  assign o_gen_clk     = gen_q;

endmodule

// File: tb/tb_freq_gen_block.sv
// tb/tb_freq_gen_block.sv - scoreboard testbench for freq_gen_block
module tb_freq_gen_block;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [19:0] i_freq_khz;
  logic        i_freq_load;
  logic        o_busy;
  logic        o_err;
  logic [19:0] o_freq_active;
  logic        o_gen_clk;

  always #5 clk = ~clk;

  freq_gen_block #(.C_REF_FREQ(100000000), .C_ACC_W(32)) dut (
    .i_ref_clk     (clk),
    .i_rst_n       (i_rst_n),
    .i_freq_khz    (i_freq_khz),
    .i_freq_load   (i_freq_load),
    .o_busy        (o_busy),
    .o_err         (o_err),
    .o_freq_active (o_freq_active),
    .o_gen_clk     (o_gen_clk)
  );

  typedef struct {
    logic [19:0] freq;
    logic [31:0] inc;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: completion (o_busy falling) pops a frequency/increment expectation;
  // every o_err cycle consumes one expected rejection.
  logic busy_prev = 1'b0;
  logic err_prev  = 1'b0;
  always @(negedge clk) begin
    if (i_rst_n === 1'b1) begin
      if (busy_prev && !o_busy) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("freq_active", o_freq_active, e.freq);
          check("inc", dut.inc_q, e.inc);
        end
      end
      if (o_err) begin
        check("err_width", err_prev, 0);
        check("err_expected", err_exp > 0, 1);
        if (err_exp > 0) err_exp--;
      end
    end
    busy_prev = o_busy;
    err_prev  = o_err;
  end

  task automatic load(input logic [19:0] f, input bit expect_err, input logic [31:0] inc);
    if (expect_err) err_exp++;
    else exp_q.push_back('{f, inc});
    i_freq_khz  = f;
    i_freq_load = 1'b1;
    @(posedge clk);
    #1;
    i_freq_load = 1'b0;
  endtask

  // Latency counted from the load cycle to the first cycle that shows o_busy low.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_busy && lat < 400);
    if (o_busy) check("busy_timeout", 1, 0);
  endtask

  // Phase statistics of o_gen_clk; the first partial phase is not counted.
  task automatic measure(input int n, output int rises, output int min_hi, output int max_hi,
                         output int min_lo, output int max_lo, output int highs);
    logic prev;
    int   run;
    bit   first;
    rises = 0; highs = 0;
    min_hi = 1000000; max_hi = 0; min_lo = 1000000; max_lo = 0;
    @(negedge clk);
    prev = o_gen_clk; run = 1; first = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_gen_clk) highs++;
      if (o_gen_clk == prev) begin
        run++;
      end else begin
        if (!first) begin
          if (prev) begin
            if (run < min_hi) min_hi = run;
            if (run > max_hi) max_hi = run;
          end else begin
            if (run < min_lo) min_lo = run;
            if (run > max_lo) max_lo = run;
          end
        end
        first = 1'b0;
        if (o_gen_clk) rises++;
        run = 1;
        prev = o_gen_clk;
      end
    end
  endtask

  int lat, rises, mnh, mxh, mnl, mxl, highs;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_freq_khz = '0; i_freq_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_freq", o_freq_active, 0);
    check("rst_gen", o_gen_clk, 0);
    check("rst_inc", dut.inc_q, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 25000 kHz -> period 4, 2 high / 2 low
    load(20'd25000, 1'b0, 32'h40000000);
    wait_done(lat);
    check("lat_25000", lat, 54);
    measure(40, rises, mnh, mxh, mnl, mxl, highs);
    check("t1_hi_min", mnh, 2); check("t1_hi_max", mxh, 2);
    check("t1_lo_min", mnl, 2); check("t1_lo_max", mxl, 2);

    // 2: 10000 kHz -> 999 or 1000 rising edges over 10000 clocks
    load(20'd10000, 1'b0, 32'h19999999);
    wait_done(lat);
`ifdef FREQ_GEN_SYNC_APPLY_EN
    check("lat_10000", lat >= 54, 1);
`else
    check("lat_10000", lat, 54);
`endif
    measure(10000, rises, mnh, mxh, mnl, mxl, highs);
    check("t2_rises", (rises == 999) || (rises == 1000), 1);
    check("t2_freq", o_freq_active, 10000);

    // 3: out-of-range requests rejected, setting kept
    load(20'd50000, 1'b1, 32'h0);
    repeat (2) @(posedge clk); #1;
    load(20'd60000, 1'b1, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("t3_busy", o_busy, 0);
    end
    check("t3_freq", o_freq_active, 10000);

    // Largest legal request
    load(20'd49999, 1'b0, 32'h7FFF583A);
    wait_done(lat);
    check("max_freq", o_freq_active, 49999);

    // 4: request during computation rejected
    load(20'd12500, 1'b0, 32'h20000000);
    repeat (2) @(posedge clk); #1;
    load(20'd20000, 1'b1, 32'h0);
    wait_done(lat);
    measure(80, rises, mnh, mxh, mnl, mxl, highs);
    check("t4_freq", o_freq_active, 12500);
    check("t4_hi_min", mnh, 4); check("t4_hi_max", mxh, 4);
    check("t4_lo_min", mnl, 4); check("t4_lo_max", mxl, 4);

    // 5: zero frequency is legal and stops the output
    load(20'd25000, 1'b0, 32'h40000000);
    wait_done(lat);
    load(20'd0, 1'b0, 32'h0);
    wait_done(lat);
    repeat (2) @(negedge clk);
    measure(100, rises, mnh, mxh, mnl, mxl, highs);
    check("t5_highs", highs, 0);
    check("t5_freq", o_freq_active, 0);

`ifdef FREQ_GEN_SYNC_APPLY_EN
    load(20'd25000, 1'b0, 32'h40000000);
    wait_done(lat);
    fork
      measure(300, rises, mnh, mxh, mnl, mxl, highs);
      begin
        @(posedge clk); #1;
        load(20'd12500, 1'b0, 32'h20000000);
        wait_done(lat);
      end
    join
    check("sync_hi_min", mnh >= 2, 1);
    check("sync_lo_min", mnl >= 2, 1);
`endif

    // 6: reset at DIV iteration 20 aborts everything
    load(20'd25000, 1'b0, 32'h40000000);
    repeat (20) @(posedge clk);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_busy", o_busy, 0);
    check("t6_freq", o_freq_active, 0);
    check("t6_gen", o_gen_clk, 0);
    check("t6_state", dut.state_q, 0);
    check("t6_inc", dut.inc_q, 0);
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    measure(20, rises, mnh, mxh, mnl, mxl, highs);
    check("t6_idle_highs", highs, 0);
    load(20'd25000, 1'b0, 32'h40000000);
    wait_done(lat);
    check("t6_lat", lat, 54);
    measure(40, rises, mnh, mxh, mnl, mxl, highs);
    check("t6_hi", (mnh == 2) && (mxh == 2), 1);
    check("t6_lo", (mnl == 2) && (mxl == 2), 1);

    repeat (3) @(negedge clk);
    check("err_pending", err_exp, 0);
    check("exp_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
